// File: rtl/vram_fill.sv
// rtl/vram_fill.sv - dual-copy VRAM with registered read ports and a block-fill engine
module vram_fill #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [ADDR_W-1:0] vramWrAddr,
  input  logic [DATA_W-1:0] vramWrData,
  input  logic              vramWr,
  input  logic [ADDR_W-1:0] vramRdAddr,
  output logic [DATA_W-1:0] vramRdData,
  input  logic [ADDR_W-1:0] vramRdAddr2,
  output logic [DATA_W-1:0] vramRdData2,
  input  logic              fillStart,
  input  logic [ADDR_W-1:0] fillAddr,
  input  logic [ADDR_W:0]   fillLen,
  input  logic [DATA_W-1:0] fillData,
  input  logic              fillAbort,
  output logic              fillBusy,
  output logic              fillDone
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_ONE = 1;
  localparam logic [ADDR_W:0]   REM_ONE = 1;

  typedef enum logic [1:0] {IDLE, FILL, DONE} fillState_t;

  fillState_t        state, stateNext;
  logic [ADDR_W-1:0] fillPtr, fillPtrNext;
  logic [ADDR_W:0]   fillRem, fillRemNext;
  logic [DATA_W-1:0] fillVal, fillValNext;

  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memData;

  // One copy per read port so both ports can read independently every cycle
  logic [DATA_W-1:0] memA [DEPTH];
  logic [DATA_W-1:0] memB [DEPTH];

  // Fill state and working registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= IDLE;
      fillPtr <= '0;
      fillRem <= '0;
      fillVal <= '0;
    end else begin
      state   <= stateNext;
      fillPtr <= fillPtrNext;
      fillRem <= fillRemNext;
      fillVal <= fillValNext;
    end
  end

  // Next state, fill bookkeeping and the single shared write port (host write wins)
  always_comb begin
    stateNext   = state;
    fillPtrNext = fillPtr;
    fillRemNext = fillRem;
    fillValNext = fillVal;
    memWe       = vramWr;
    memAddr     = vramWrAddr;
    memData     = vramWrData;
    fillBusy    = 1'b0;
    fillDone    = 1'b0;
    case (state)
      IDLE: begin
        if (fillStart) begin
          fillPtrNext = fillAddr;
          fillRemNext = fillLen;
          fillValNext = fillData;
          stateNext   = (fillLen == '0) ? DONE : FILL;
        end
      end
      FILL: begin
        fillBusy = 1'b1;
        if (fillAbort) begin
          stateNext = IDLE;
        end else if (!vramWr) begin
          memWe       = 1'b1;
          memAddr     = fillPtr;
          memData     = fillVal;
          fillPtrNext = fillPtr + PTR_ONE;
          fillRemNext = fillRem - REM_ONE;
          if (fillRem == REM_ONE) stateNext = DONE;
        end
      end
      DONE: begin
        fillDone  = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Storage is never reset; both copies take every write
  always_ff @(posedge clk) begin
    if (memWe) begin
      memA[memAddr] <= memData;
      memB[memAddr] <= memData;
    end
  end

  // Registered read-first outputs
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      vramRdData  <= '0;
      vramRdData2 <= '0;
    end else begin
      vramRdData  <= memA[vramRdAddr];
      vramRdData2 <= memB[vramRdAddr2];
    end
  end

endmodule

// File: tb/tb_vram_fill.sv
// tb/tb_vram_fill.sv - scoreboard bench for vram_fill against a queue-based reference model
module tb_vram_fill;

  localparam int AW = 13;
  localparam int DW = 8;
  localparam int DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          nrst;
  logic [AW-1:0] vramWrAddr, vramRdAddr, vramRdAddr2, fillAddr;
  logic [DW-1:0] vramWrData, vramRdData, vramRdData2, fillData;
  logic          vramWr, fillStart, fillAbort, fillBusy, fillDone;
  logic [AW:0]   fillLen;

  vram_fill #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .nrst(nrst),
    .vramWrAddr(vramWrAddr), .vramWrData(vramWrData), .vramWr(vramWr),
    .vramRdAddr(vramRdAddr), .vramRdData(vramRdData),
    .vramRdAddr2(vramRdAddr2), .vramRdData2(vramRdData2),
    .fillStart(fillStart), .fillAddr(fillAddr), .fillLen(fillLen), .fillData(fillData),
    .fillAbort(fillAbort), .fillBusy(fillBusy), .fillDone(fillDone)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] rd;
    logic [DW-1:0] rd2;
    bit            v1;
    bit            v2;
    bit            busy;
    bit            done;
  } exp_t;

  exp_t          sb[$];
  int            nCmp = 0;
  int            nBad = 0;

  // reference model: memory image, which words are known, addresses still to fill
  logic [DW-1:0] mem [DEPTH];
  bit            known [DEPTH];
  logic [AW-1:0] pend[$];
  logic [DW-1:0] mVal;
  bit            mDone;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] rndAddr();
    logic [AW-1:0] a;
    a = AW'($urandom_range(0, 47));
    if ($urandom_range(0, 1) == 1) a = a - AW'(24);
    return a;
  endfunction

  // Called at a negedge with inputs driven; predicts outputs after the coming posedge
  task automatic apply();
    exp_t          e;
    logic [AW-1:0] a;
    e.v1  = known[vramRdAddr];
    e.rd  = mem[vramRdAddr];
    e.v2  = known[vramRdAddr2];
    e.rd2 = mem[vramRdAddr2];
    if (vramWr) begin
      mem[vramWrAddr]   = vramWrData;
      known[vramWrAddr] = 1'b1;
    end
    if (pend.size() > 0) begin
      if (fillAbort) pend.delete();
      else if (!vramWr) begin
        a = pend.pop_front();
        mem[a]   = mVal;
        known[a] = 1'b1;
        if (pend.size() == 0) mDone = 1'b1;
      end
    end else if (mDone) begin
      mDone = 1'b0;
    end else if (fillStart) begin
      mVal = fillData;
      if (fillLen == 0) mDone = 1'b1;
      else for (int i = 0; i < int'(fillLen); i++) pend.push_back(fillAddr + AW'(i));
    end
    e.busy = (pend.size() > 0);
    e.done = mDone;
    sb.push_back(e);
    @(negedge clk);
    vramWr    = 1'b0;
    fillStart = 1'b0;
    fillAbort = 1'b0;
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while ((pend.size() > 0 || mDone) && n < bound) begin
      vramRdAddr  = rndAddr();
      vramRdAddr2 = rndAddr();
      apply();
      n++;
    end
    chk("drain_bound", (n < bound) ? 1 : 0, 1);
  endtask

  task automatic startFill(input logic [AW-1:0] a, input logic [AW:0] len, input logic [DW-1:0] d);
    fillStart = 1'b1;
    fillAddr  = a;
    fillLen   = len;
    fillData  = d;
    apply();
  endtask

  task automatic readBoth(input logic [AW-1:0] a, input logic [AW-1:0] b);
    vramRdAddr  = a;
    vramRdAddr2 = b;
    apply();
  endtask

  // Monitor: pops one prediction per clock in which one was issued
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.v1) chk("rdData", vramRdData, e.rd);
        if (e.v2) chk("rdData2", vramRdData2, e.rd2);
        chk("fillBusy", fillBusy, e.busy);
        chk("fillDone", fillDone, e.done);
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    nrst = 1'b0;
    vramWr = 1'b0; vramWrAddr = '0; vramWrData = '0;
    vramRdAddr = '0; vramRdAddr2 = '0;
    fillStart = 1'b0; fillAddr = '0; fillLen = '0; fillData = '0; fillAbort = 1'b0;
    mDone = 1'b0; mVal = '0;
    for (int i = 0; i < DEPTH; i++) begin known[i] = 1'b0; mem[i] = '0; end

    #3;
    chk("reset_busy", fillBusy, 0);
    chk("reset_done", fillDone, 0);
    chk("reset_rd", vramRdData, 0);
    chk("reset_rd2", vramRdData2, 0);
    @(negedge clk);
    nrst = 1'b1;

    // full-depth fill with wrap: initialises every word
    startFill(13'h0123, 14'd8192, 8'h3C);
    drain(9000);
    readBoth(13'h0122, 13'h1FFF);
    readBoth(13'h0000, 13'h0123);

    // write then read both ports
    vramWr = 1'b1; vramWrAddr = 13'h0100; vramWrData = 8'h5A;
    apply();
    readBoth(13'h0100, 13'h0100);

    // read-first on same-cycle write
    vramWr = 1'b1; vramWrAddr = 13'h0020; vramWrData = 8'h22;
    apply();
    vramWr = 1'b1; vramWrAddr = 13'h0020; vramWrData = 8'h11;
    readBoth(13'h0020, 13'h0020);
    readBoth(13'h0020, 13'h0020);

    // fill wrapping across the top address
    startFill(13'h1FFE, 14'd4, 8'hAA);
    drain(20);
    readBoth(13'h1FFE, 13'h1FFF);
    readBoth(13'h0000, 13'h0001);
    readBoth(13'h0002, 13'h1FFD);

    // host writes stall an 8-word fill; one behind the fill, one ahead of it
    startFill(13'h0040, 14'd8, 8'h77);
    readBoth(13'h0040, 13'h0041);
    readBoth(13'h0042, 13'h0043);
    vramWr = 1'b1; vramWrAddr = 13'h0041; vramWrData = 8'h99;
    apply();
    vramWr = 1'b1; vramWrAddr = 13'h0046; vramWrData = 8'h55;
    apply();
    drain(20);
    readBoth(13'h0041, 13'h0046);
    readBoth(13'h0047, 13'h0048);

    // abort after 3 words, immediately followed by a new fill
    startFill(13'h0200, 14'd16, 8'hC3);
    readBoth(13'h0200, 13'h0203);
    readBoth(13'h0201, 13'h0202);
    readBoth(13'h0202, 13'h0203);
    fillAbort = 1'b1;
    apply();
    startFill(13'h0300, 14'd2, 8'h5E);
    drain(20);
    readBoth(13'h0202, 13'h0203);
    readBoth(13'h0300, 13'h0301);

    // zero-length fill
    startFill(13'h0500, 14'd0, 8'hEE);
    readBoth(13'h0500, 13'h0500);
    readBoth(13'h0500, 13'h0500);

    // reset in the middle of a fill
    startFill(13'h0400, 14'd20, 8'h6D);
    for (int i = 0; i < 5; i++) readBoth(13'h0400 + AW'(i), 13'h0410);
    nrst = 1'b0;
    #1;
    chk("midreset_busy", fillBusy, 0);
    chk("midreset_done", fillDone, 0);
    chk("midreset_rd", vramRdData, 0);
    chk("midreset_rd2", vramRdData2, 0);
    pend.delete();
    mDone = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    for (int i = 0; i < 8; i++) readBoth(13'h03FF + AW'(i), 13'h0413 - AW'(i));

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      vramRdAddr  = rndAddr();
      vramRdAddr2 = rndAddr();
      if ($urandom_range(0, 3) == 0) begin
        vramWr = 1'b1; vramWrAddr = rndAddr(); vramWrData = DW'($urandom);
      end
      if ($urandom_range(0, 7) == 0) begin
        fillStart = 1'b1; fillAddr = rndAddr();
        fillLen = (AW+1)'($urandom_range(0, 24)); fillData = DW'($urandom);
      end
      if ($urandom_range(0, 29) == 0) fillAbort = 1'b1;
      apply();
    end
    drain(100);

    @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule

// File: doc/vram_fill.md
VRAM_FILL -- requirements
Module: vram_fill

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, meaning address width; depth is 2**ADDR_W words.
REQ-002 SHALL have parameter DATA_W, default 8, meaning word width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port nrst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port vramWrAddr, input, ADDR_W bits: host write address.
REQ-006 SHALL have port vramWrData, input, DATA_W bits: host write data.
REQ-007 SHALL have port vramWr, input, 1 bit: host write strobe, 1=write this cycle.
REQ-008 SHALL have port vramRdAddr, input, ADDR_W bits: display-side read address.
REQ-009 SHALL have port vramRdData, output, DATA_W bits: display-side read data.
REQ-010 SHALL have port vramRdAddr2, input, ADDR_W bits: host-side read address.
REQ-011 SHALL have port vramRdData2, output, DATA_W bits: host-side read data.
REQ-012 SHALL have port fillStart, input, 1 bit: one-cycle request to start a block fill.
REQ-013 SHALL have port fillAddr, input, ADDR_W bits: fill start address, sampled on accepted fillStart.
REQ-014 SHALL have port fillLen, input, ADDR_W+1 bits: word count, 0..2**ADDR_W, sampled on accepted fillStart.
REQ-015 SHALL have port fillData, input, DATA_W bits: fill value, sampled on accepted fillStart.
REQ-016 SHALL have port fillAbort, input, 1 bit: terminate an active fill.
REQ-017 SHALL have port fillBusy, output, 1 bit: fill engine active.
REQ-018 SHALL have port fillDone, output, 1 bit: one-cycle pulse when a fill completes normally.

Function
REQ-019 SHALL keep two identical storage copies; every write updates both copies in the same cycle.
REQ-020 Each read port SHALL read its own copy and register the result: data for the address presented in cycle N appears at the output in cycle N+1.
REQ-021 A read of an address written in the same cycle SHALL return the old contents (read-first); the new value SHALL be visible from the following read.
REQ-022 The fill FSM SHALL have states IDLE, FILL and DONE; fillBusy=1 exactly in FILL; fillDone=1 exactly in DONE.
REQ-023 In IDLE, fillStart=1 SHALL latch fillAddr, fillLen and fillData; fillLen=0 goes to DONE, otherwise goes to FILL.
REQ-024 fillStart SHALL be ignored in FILL and DONE.
REQ-025 In FILL, each cycle without vramWr SHALL write fillData at the current address, increment the address modulo 2**ADDR_W, and decrement the remaining count.
REQ-026 When the word just written is the last one (remaining count 1), FILL SHALL go to DONE.
REQ-027 From DONE, the FSM SHALL return to IDLE after one cycle.
REQ-028 Host writes SHALL have priority: when vramWr=1 in FILL, only the host write occurs and the fill address and count do not change that cycle.
REQ-029 fillAbort=1 in FILL SHALL return to IDLE on the next edge; no fill write occurs that cycle and fillDone is not pulsed.
REQ-030 fillAbort SHALL take precedence over both a normal fill write and completion.
REQ-031 A host write to an address the fill will reach later SHALL be overwritten by the fill when the fill reaches that address.
REQ-032 fillLen=2**ADDR_W SHALL write every word exactly once, wrapping from the top address to 0.
REQ-033 The fill takes exactly fillLen cycles in FILL plus the number of stall cycles.

Reset
REQ-034 When nrst=0 the block SHALL immediately enter IDLE with fillBusy=0, fillDone=0, vramRdData=0 and vramRdData2=0, and clear the internal fill registers.
REQ-035 Reset SHALL NOT clear memory contents; a fill interrupted by reset leaves the words already written unchanged and the rest untouched.

Verification
REQ-036 ADDR_W=13: write 0x5A to address 0x0100, then read on both ports -> both outputs show 0x5A one cycle after the address is presented.
REQ-037 Same-cycle write 0x11 and read of address 0x0020, which holds 0x22 -> output shows 0x22; the next read shows 0x11.
REQ-038 fillStart with fillAddr=0x1FFE, fillLen=4, fillData=0xAA -> addresses 0x1FFE, 0x1FFF, 0x0000 and 0x0001 become 0xAA; fillBusy is high for 4 cycles; then one fillDone pulse.
REQ-039 Fill of 8 words with vramWr asserted for 2 cycles mid-fill -> fillBusy is high for 10 cycles; the host-written words hold host data unless inside the unfilled remainder.
REQ-040 fillAbort after 3 words of a 16-word fill -> exactly 3 words filled; no fillDone; a fillStart issued next cycle is accepted.
REQ-041 fillLen=0 -> no writes, fillBusy stays 0, fillDone pulses one cycle after fillStart; nrst pulsed mid-fill -> outputs 0 immediately, memory retains the partial fill.
